// File: rtl/mips32_pipe_fwd.sv
// Five-stage MIPS32 core with forwarding/interlock, load-use stall, branch flush in EX,
// external instruction/data memory ports and a retire trace taken from the WB stage.
`timescale 1ns/1ps
module mips32_pipe_fwd #(
    parameter int              PC_W     = 10,
    parameter logic [PC_W-1:0] RESET_PC = '0,
    parameter bit              FWD_EN   = 1'b1
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic [PC_W-1:0] imem_addr,
    input  logic [31:0]     imem_rdata,
    output logic [PC_W-1:0] dmem_addr,
    output logic [31:0]     dmem_wdata,
    output logic            dmem_we,
    input  logic [31:0]     dmem_rdata,
    output logic            halted,
    output logic            retire_valid,
    output logic [4:0]      retire_rd,
    output logic [31:0]     retire_data
);
    localparam logic [5:0] OP_ADDI = 6'b001010, OP_SUBI = 6'b001011, OP_SLTI = 6'b001100;
    localparam logic [5:0] OP_LW = 6'b001000, OP_SW = 6'b001001;
    localparam logic [5:0] OP_BNEQZ = 6'b001101, OP_BEQZ = 6'b001110;

    function automatic logic reads_reg(input logic [4:0] dest, input logic [4:0] rs,
                                       input logic [4:0] rt, input logic use_rs,
                                       input logic use_rt);
        return (dest != 5'd0) && ((use_rs && dest == rs) || (use_rt && dest == rt));
    endfunction

    logic [PC_W-1:0] r_pc;
    logic            r_fetch_stop, r_halted;
    logic [31:0]     r_rf [32];

    logic            r_ifid_valid;
    logic [31:0]     r_ifid_ir;
    logic [PC_W-1:0] r_ifid_pc;

    logic            r_idex_valid, r_idex_lw, r_idex_sw, r_idex_br, r_idex_beqz, r_idex_hlt;
    logic            r_idex_useimm;
    logic [2:0]      r_idex_fn;
    logic [4:0]      r_idex_rs, r_idex_rt, r_idex_dest;
    logic [31:0]     r_idex_a, r_idex_b, r_idex_imm;
    logic [PC_W-1:0] r_idex_pc1;

    logic            r_exmem_valid, r_exmem_lw, r_exmem_sw, r_exmem_hlt;
    logic [4:0]      r_exmem_dest;
    logic [31:0]     r_exmem_res, r_exmem_sdata;

    logic            r_memwb_valid, r_memwb_hlt;
    logic [4:0]      r_memwb_dest;
    logic [31:0]     r_memwb_data;

    // ID decode
    logic [5:0]  w_op;
    logic [4:0]  w_rs, w_rt, w_rd, w_dest;
    logic [31:0] w_imm, w_rs_val, w_rt_val;
    logic        w_is_rr, w_is_imm, w_is_lw, w_is_sw, w_is_br, w_is_hlt, w_use_rs, w_use_rt;
    logic [2:0]  w_fn;
    logic        w_wb_we, w_hz_ex, w_hz_mem, w_hz_wb, w_stall, w_id_hlt, w_fetch_stop;

    assign w_op     = r_ifid_ir[31:26];
    assign w_rs     = r_ifid_ir[25:21];
    assign w_rt     = r_ifid_ir[20:16];
    assign w_rd     = r_ifid_ir[15:11];
    assign w_imm    = {{16{r_ifid_ir[15]}}, r_ifid_ir[15:0]};
    assign w_is_rr  = (w_op[5:3] == 3'b000) && (w_op[2:0] <= 3'd5);
    assign w_is_imm = (w_op == OP_ADDI) || (w_op == OP_SUBI) || (w_op == OP_SLTI);
    assign w_is_lw  = (w_op == OP_LW);
    assign w_is_sw  = (w_op == OP_SW);
    assign w_is_br  = (w_op == OP_BNEQZ) || (w_op == OP_BEQZ);
    assign w_is_hlt = !(w_is_rr || w_is_imm || w_is_lw || w_is_sw || w_is_br);
    assign w_use_rs = !w_is_hlt;
    assign w_use_rt = w_is_rr || w_is_sw;
    assign w_dest   = w_is_rr ? w_rd : ((w_is_imm || w_is_lw) ? w_rt : 5'd0);
    assign w_fn     = w_is_rr ? w_op[2:0] : (w_op == OP_SUBI) ? 3'd1 : (w_op == OP_SLTI) ? 3'd4 : 3'd0;

    // Write-first register file: the WB write is bypassed into the ID read.
    assign w_wb_we  = r_memwb_valid && (r_memwb_dest != 5'd0);
    assign w_rs_val = (w_wb_we && r_memwb_dest == w_rs) ? r_memwb_data : r_rf[w_rs];
    assign w_rt_val = (w_wb_we && r_memwb_dest == w_rt) ? r_memwb_data : r_rf[w_rt];

    assign w_hz_ex  = r_idex_valid  && reads_reg(r_idex_dest,  w_rs, w_rt, w_use_rs, w_use_rt);
    assign w_hz_mem = r_exmem_valid && reads_reg(r_exmem_dest, w_rs, w_rt, w_use_rs, w_use_rt);
    assign w_hz_wb  = r_memwb_valid && reads_reg(r_memwb_dest, w_rs, w_rt, w_use_rs, w_use_rt);
    assign w_stall  = r_ifid_valid && (FWD_EN ? (w_hz_ex && r_idex_lw)
                                              : (w_hz_ex || w_hz_mem || w_hz_wb));

    // EX with forwarding; a LW in EX/MEM has no result yet and is never a source.
    logic [31:0]     w_a, w_b, w_opb, w_res;
    logic            w_taken;
    logic [PC_W-1:0] w_target;

    always_comb begin
        w_a = r_idex_a;
        w_b = r_idex_b;
        if (FWD_EN && r_exmem_valid && !r_exmem_lw && r_exmem_dest != 5'd0 && r_exmem_dest == r_idex_rs)
            w_a = r_exmem_res;
        else if (FWD_EN && w_wb_we && r_memwb_dest == r_idex_rs)
            w_a = r_memwb_data;
        if (FWD_EN && r_exmem_valid && !r_exmem_lw && r_exmem_dest != 5'd0 && r_exmem_dest == r_idex_rt)
            w_b = r_exmem_res;
        else if (FWD_EN && w_wb_we && r_memwb_dest == r_idex_rt)
            w_b = r_memwb_data;
    end

    assign w_opb = r_idex_useimm ? r_idex_imm : w_b;

    always_comb begin
        w_res = w_a + w_opb;
        case (r_idex_fn)
            3'd1:    w_res = w_a - w_opb;
            3'd2:    w_res = w_a & w_opb;
            3'd3:    w_res = w_a | w_opb;
            3'd4:    w_res = {31'd0, $signed(w_a) < $signed(w_opb)};
            3'd5:    w_res = w_a * w_opb;
            default: w_res = w_a + w_opb;
        endcase
    end

    assign w_taken      = r_idex_valid && r_idex_br && (r_idex_beqz ? (w_a == 32'd0) : (w_a != 32'd0));
    assign w_target     = r_idex_pc1 + r_idex_imm[PC_W-1:0];
    assign w_id_hlt     = r_ifid_valid && w_is_hlt;
    assign w_fetch_stop = r_fetch_stop || (w_id_hlt && !w_taken);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc <= RESET_PC;  r_fetch_stop <= 1'b0;  r_halted <= 1'b0;
            r_ifid_valid <= 1'b0;  r_ifid_ir <= '0;  r_ifid_pc <= '0;
            r_idex_valid <= 1'b0;  r_idex_lw <= 1'b0;  r_idex_sw <= 1'b0;  r_idex_br <= 1'b0;
            r_idex_beqz <= 1'b0;  r_idex_hlt <= 1'b0;  r_idex_useimm <= 1'b0;  r_idex_fn <= '0;
            r_idex_rs <= '0;  r_idex_rt <= '0;  r_idex_dest <= '0;
            r_idex_a <= '0;  r_idex_b <= '0;  r_idex_imm <= '0;  r_idex_pc1 <= '0;
            r_exmem_valid <= 1'b0;  r_exmem_lw <= 1'b0;  r_exmem_sw <= 1'b0;  r_exmem_hlt <= 1'b0;
            r_exmem_dest <= '0;  r_exmem_res <= '0;  r_exmem_sdata <= '0;
            r_memwb_valid <= 1'b0;  r_memwb_hlt <= 1'b0;  r_memwb_dest <= '0;  r_memwb_data <= '0;
        end else if (!r_halted) begin
            r_halted <= r_memwb_valid && r_memwb_hlt;
            if (w_id_hlt && !w_taken) r_fetch_stop <= 1'b1;

            if (w_taken)                       r_pc <= w_target;
            else if (!w_stall && !w_fetch_stop) r_pc <= r_pc + PC_W'(1);

            if (w_taken || (!w_stall && w_fetch_stop)) begin
                r_ifid_valid <= 1'b0;
            end else if (!w_stall) begin
                r_ifid_valid <= 1'b1;
                r_ifid_ir    <= imem_rdata;
                r_ifid_pc    <= r_pc;
            end

            r_idex_valid  <= r_ifid_valid && !w_taken && !w_stall;
            r_idex_lw     <= w_is_lw;
            r_idex_sw     <= w_is_sw;
            r_idex_br     <= w_is_br;
            r_idex_beqz   <= (w_op == OP_BEQZ);
            r_idex_hlt    <= w_is_hlt;
            r_idex_useimm <= !w_is_rr;
            r_idex_fn     <= w_fn;
            r_idex_rs     <= w_rs;
            r_idex_rt     <= w_rt;
            r_idex_dest   <= w_dest;
            r_idex_a      <= w_rs_val;
            r_idex_b      <= w_rt_val;
            r_idex_imm    <= w_imm;
            r_idex_pc1    <= r_ifid_pc + PC_W'(1);

            r_exmem_valid <= r_idex_valid;
            r_exmem_lw    <= r_idex_lw;
            r_exmem_sw    <= r_idex_sw;
            r_exmem_hlt   <= r_idex_hlt;
            r_exmem_dest  <= r_idex_dest;
            r_exmem_res   <= w_res;
            r_exmem_sdata <= w_b;

            r_memwb_valid <= r_exmem_valid;
            r_memwb_hlt   <= r_exmem_hlt;
            r_memwb_dest  <= r_exmem_dest;
            r_memwb_data  <= (r_exmem_dest == 5'd0) ? 32'd0 : (r_exmem_lw ? dmem_rdata : r_exmem_res);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) r_rf[i] <= '0;
        end else if (w_wb_we && !r_halted) begin
            r_rf[r_memwb_dest] <= r_memwb_data;
        end
    end

    assign imem_addr    = r_pc;
    assign dmem_addr    = r_exmem_res[PC_W-1:0];
    assign dmem_wdata   = r_exmem_sdata;
    assign dmem_we      = r_exmem_valid && r_exmem_sw && !r_halted;
    assign halted       = r_halted;
    assign retire_valid = r_memwb_valid && !r_halted;
    assign retire_rd    = retire_valid ? r_memwb_dest : 5'd0;
    assign retire_data  = retire_valid ? r_memwb_data : 32'd0;
endmodule

// File: doc/mips32_pipe_fwd.md
# mips32_pipe_fwd

Single-clock, parametrised successor of the team's 5-stage MIPS32 pipeline (IF, ID, EX, MEM, WB). It runs the same 32-bit ISA and encodings. Over the two-phase version it adds:
- hazard handling: operand forwarding or interlock, plus load-use stall;
- branch flush;
- external instruction and data memory ports;
- a retire trace port.

It sits between the instruction/data memories and the system bench, as the CPU core.

## Interface
Parameters:
- `PC_W`, default 10: PC/word-address width; memories are 2^PC_W words.
- `RESET_PC`, default 0: PC value loaded on reset.
- `FWD_EN`, default 1:
  - 1: EX/MEM and MEM/WB forwarding to EX.
  - 0: no forwarding; ID stalls on any RAW against EX/MEM/WB.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `imem_addr`  out  PC_W  fetch word address (= PC).
- `imem_rdata`  in  32  instruction; combinational read of imem_addr.
- `dmem_addr`  out  PC_W  data word address, low PC_W bits of the EX/MEM ALU result.
- `dmem_wdata`  out  32  store data.
- `dmem_we`  out  1  store strobe, one cycle per SW.
- `dmem_rdata`  in  32  load data; combinational read of dmem_addr.
- `halted`  out  1  sticky; set when HLT retires.
- `retire_valid`  out  1  an instruction left WB this cycle.
- `retire_rd`  out  5  destination register (0 if no write).
- `retire_data`  out  32  value written.

## Operation
Encodings (opcode = IR[31:26]):
- RR ALU: ADD 000000, SUB 000001, AND 000010, OR 000011, SLT 000100, MUL 000101. rd = IR[15:11], sources rs = IR[25:21], rt = IR[20:16].
- Immediate: ADDI 001010, SUBI 001011, SLTI 001100. rt = rs op sext(IR[15:0]).
- Memory: LW 001000 (rt = M[rs+imm]), SW 001001 (M[rs+imm] = rt).
- Branch: BNEQZ 001101, BEQZ 001110. Target = PC+1+sext(imm); condition tests rs.
- HLT 111111. Any undefined opcode is treated as HLT.

Arithmetic and widths:
- All arithmetic is 32-bit two's complement, truncated.
- MUL keeps the low 32 bits.
- SLT/SLTI compare signed and produce 0 or 1.
- Addresses use the low PC_W bits of the result.

Register file:
- 32×32; R0 reads 0 and writes to it are dropped.
- Write-first: a WB write is visible to the ID read in the same cycle.

Pipeline and hazards:
- Each stage register carries a valid bit; bubbles have valid=0 and no side effects.
- Forwarding (FWD_EN=1): EX operand priority is EX/MEM result, then MEM/WB result, then ID/EX value. Never from a LW still in EX/MEM. Branch condition uses the forwarded rs.
- Load-use: an instruction in ID that reads the rt of a LW in EX stalls 1 cycle. PC and IF/ID hold; a bubble goes to EX.
- FWD_EN=0: ID stalls while any valid EX, MEM or WB instruction writes a nonzero register that ID reads.
- Branch resolves in EX. If taken, PC loads the target and IF/ID and ID/EX are flushed (2-cycle penalty). Not-taken costs nothing.
- HLT:
  - Once decoded in ID, fetch freezes: PC holds and bubbles enter IF/ID.
  - Older instructions drain normally.
  - When HLT reaches WB, `halted` is set, and all state is then frozen until reset.
  - A HLT flushed by a taken branch has no effect.

## Timing
- Reset (async assert, sync-to-clk deassert is the integrator's job):
  - PC = RESET_PC; all valid bits 0; register file cleared to 0.
  - `halted` = 0, `dmem_we` = 0, `retire_valid` = 0, `retire_rd` = 0, `retire_data` = 0.
  - Reset mid-operation discards all in-flight instructions and blocks any store that cycle.
- Latency: an instruction fetched at edge n retires at edge n+4 with no stalls; CPI is 1 in steady state.
- Simultaneous events: a taken branch in EX overrides a load-use stall in ID, because the stalled instruction is flushed.
- `dmem_we` is asserted combinationally from a valid EX/MEM SW; the write happens at the next edge.
- PC wraps modulo 2^PC_W.

## Test plan
- Independent ops: R1=ADDI R0,5; R2=ADDI R0,7; R3=ADD R1,R2; HLT → R3=12 with no stall cycles; `halted` rises 4 cycles after HLT is fetched, plus drain.
- Back-to-back RAW, FWD_EN=1: ADDI R1,R0,3; ADD R2,R1,R1; MUL R3,R2,R1 → R2=6, R3=18, CPI 1. Same program with FWD_EN=0 → same results, 3 stall cycles per dependency.
- Load-use: SW R5=0xABCD to M[20]; LW R6,20(R0); ADDI R7,R6,1 → exactly one bubble, R7=0xABCE.
- Branch loop: R1=3; loop body SUBI R1,R1,1; BNEQZ R1,-2 → 3 iterations, final R1=0. Each taken branch squashes 2 younger instructions; a squashed SW leaves memory unchanged.
- Writes to R0 and undefined opcode: ADDI R0,R0,9 → R0 reads 0 and retire_rd=0. Opcode 010101 halts like HLT.
- Async reset while a SW is in EX/MEM → no memory write; all outputs return to their reset values; execution restarts at RESET_PC.
